dm_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port synchronous data RAM.
- Requester 0 is the CPU MEM stage; requester 1 is the DMA/debug bridge.
- Per granted access, the block generates the RAM enable, byte-write-enables and lane-aligned write data.
- For loads, it returns lane-selected, sign- or zero-extended read data with an ack pulse.
- It flags misaligned accesses and illegal MemCodes without touching the RAM.

---
 rtl/dm_arbiter_pkg.sv | 42 ++++
 rtl/dm_arbiter_load_ext.sv | 35 +++
 rtl/dm_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_dm_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: MemCodes, FSM states and
// access classification helpers.
package dm_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam logic [3:0] MC_LW  = 4'b0000;
    localparam logic [3:0] MC_LH  = 4'b0010;
    localparam logic [3:0] MC_LB  = 4'b0011;
    localparam logic [3:0] MC_LHU = 4'b0100;
    localparam logic [3:0] MC_LBU = 4'b0101;
    localparam logic [3:0] MC_SW  = 4'b1000;
    localparam logic [3:0] MC_SH  = 4'b1010;
    localparam logic [3:0] MC_SB  = 4'b1011;

    function automatic logic is_load(input logic [3:0] code);
        case (code)
            MC_LW, MC_LH, MC_LB, MC_LHU, MC_LBU: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] code);
        case (code)
            MC_SW, MC_SH, MC_SB: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Words need lane 0, halves need an even lane; bytes are always aligned.
    function automatic logic is_misaligned(input logic [3:0] code, input logic [1:0] lane);
        case (code)
            MC_LW, MC_SW:         is_misaligned = (lane != 2'b00);
            MC_LH, MC_LHU, MC_SH: is_misaligned = lane[0];
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_arbiter_load_ext.sv
// Load lane selection and sign/zero extension of a RAM read word.
module dm_arbiter_load_ext
    import dm_arbiter_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_lane,
    input  logic [3:0]  i_code,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/half and extend it according to the MemCode
    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            2'd3:    w_byte = i_data[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_lane[1] ? i_data[31:16] : i_data[15:0];
        case (i_code)
            MC_LW:   o_data = i_data;
            MC_LH:   o_data = {{16{w_half[15]}}, w_half};
            MC_LHU:  o_data = {16'h0000, w_half};
            MC_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            MC_LBU:  o_data = {24'h000000, w_byte};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM.
// IDLE issues one access combinationally, RESP returns ack/err/rdata.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW         = 12,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [1:0]    i_req,
    input  logic [63:0]   i_addr,
    input  logic [63:0]   i_wdata,
    input  logic [7:0]    i_code,
    output logic [1:0]    o_ack,
    output logic [1:0]    o_err,
    output logic [63:0]   o_rdata,
    output logic          o_ram_en,
    output logic [3:0]    o_ram_we,
    output logic [AW-3:0] o_ram_addr,
    output logic [31:0]   o_ram_wdata,
    input  logic [31:0]   i_ram_rdata
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_gnt;
    logic        r_ptr;
    logic        r_err;
    logic [3:0]  r_code;
    logic [1:0]  r_lane;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic          w_gnt;
    logic [3:0]    w_code;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic [1:0]    w_lane;
    logic          w_bad;
    logic          w_issue;
    logic          w_resp;
    logic [1:0]    w_ack_sel;
    logic [31:0]   w_ext;
    logic [31:0]   w_resp_data;
    logic          w_addr_unused;

    // Address bits above the RAM range are ignored
    assign w_addr_unused = ^{i_addr[63:32+AW], i_addr[31:AW]};

    // Winner selection: a tie goes to the requester not granted last (or to 0)
    always_comb begin
        w_gnt = 1'b0;
        case (i_req)
            2'b01:   w_gnt = 1'b0;
            2'b10:   w_gnt = 1'b1;
            2'b11:   w_gnt = FIXED_PRIO ? 1'b0 : ~r_ptr;
            default: w_gnt = 1'b0;
        endcase
    end

    // Route the winning requester's address, data and code
    always_comb begin
        if (w_gnt) begin
            w_code  = i_code[7:4];
            w_addr  = i_addr[32+AW-1:32];
            w_wdata = i_wdata[63:32];
        end else begin
            w_code  = i_code[3:0];
            w_addr  = i_addr[AW-1:0];
            w_wdata = i_wdata[31:0];
        end
    end

    assign w_lane  = w_addr[1:0];
    assign w_bad   = !(is_load(w_code) || is_store(w_code)) || is_misaligned(w_code, w_lane);
    assign w_issue = i_reset && (r_state == ST_IDLE) && (i_req != 2'b00);
    assign w_resp  = i_reset && (r_state == ST_RESP);

    // Next-state logic: every granted access spends exactly one cycle in RESP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req != 2'b00) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM strobe, byte enables and lane-replicated store data in the issue cycle
    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 4'b0000;
        o_ram_wdata = 32'h0000_0000;
        o_ram_addr  = w_addr[AW-1:2];
        if (w_issue && !w_bad) begin
            o_ram_en = 1'b1;
            case (w_code)
                MC_SW: begin
                    o_ram_we    = 4'b1111;
                    o_ram_wdata = w_wdata;
                end
                MC_SH: begin
                    o_ram_we    = w_lane[1] ? 4'b1100 : 4'b0011;
                    o_ram_wdata = {2{w_wdata[15:0]}};
                end
                MC_SB: begin
                    o_ram_we    = 4'b0001 << w_lane;
                    o_ram_wdata = {4{w_wdata[7:0]}};
                end
                default: begin
                    o_ram_we    = 4'b0000;
                    o_ram_wdata = 32'h0000_0000;
                end
            endcase
        end else begin
            o_ram_en = 1'b0;
            o_ram_we = 4'b0000;
        end
    end

    dm_arbiter_load_ext u_load_ext (
        .i_data (i_ram_rdata),
        .i_lane (r_lane),
        .i_code (r_code),
        .o_data (w_ext)
    );

    // Response outputs: ack/err pulse in RESP, rdata follows the load or holds
    always_comb begin
        w_ack_sel   = r_gnt ? 2'b10 : 2'b01;
        o_ack       = 2'b00;
        o_err       = 2'b00;
        w_resp_data = r_gnt ? r_rdata1 : r_rdata0;
        if (w_resp) begin
            o_ack = w_ack_sel;
            if (r_err) begin
                o_err       = w_ack_sel;
                w_resp_data = 32'h0000_0000;
            end else if (is_load(r_code)) begin
                w_resp_data = w_ext;
            end else begin
                w_resp_data = r_gnt ? r_rdata1 : r_rdata0;
            end
        end else begin
            o_ack = 2'b00;
            o_err = 2'b00;
        end
        o_rdata[31:0]  = (w_resp && !r_gnt) ? w_resp_data : r_rdata0;
        o_rdata[63:32] = (w_resp &&  r_gnt) ? w_resp_data : r_rdata1;
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted access and advance the round-robin pointer on grant
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_gnt  <= 1'b0;
            r_ptr  <= 1'b1;
            r_err  <= 1'b0;
            r_code <= MC_LW;
            r_lane <= 2'b00;
        end else if (w_issue) begin
            r_gnt  <= w_gnt;
            r_ptr  <= w_gnt;
            r_err  <= w_bad;
            r_code <= w_code;
            r_lane <= w_lane;
        end
    end

    // Hold each requester's last returned data between acks
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rdata0 <= 32'h0000_0000;
            r_rdata1 <= 32'h0000_0000;
        end else if (w_resp) begin
            if (r_gnt) begin
                r_rdata1 <= w_resp_data;
            end else begin
                r_rdata0 <= w_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: vector table with a response scoreboard, a
// behavioural byte-write RAM, plus contention and reset-in-RESP sequences.
// A round-robin and a fixed-priority instance share the same stimulus.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  code;

    logic [1:0]  ack,  ack2;
    logic [1:0]  err,  err2;
    logic [63:0] rdata, rdata2;
    logic        ram_en, ram_en2;
    logic [3:0]  ram_we, ram_we2;
    logic [9:0]  ram_addr, ram_addr2;
    logic [31:0] ram_wdata, ram_wdata2;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:1023];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          rq;
        logic [3:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        en;
        logic [3:0]  we;
        logic [9:0]  waddr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } vec_t;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic        chk_rd;
        int          rq;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[16];

    dm_arbiter #(.AW(12), .FIXED_PRIO(1'b0)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr),
        .i_wdata(wdata), .i_code(code), .o_ack(ack), .o_err(err),
        .o_rdata(rdata), .o_ram_en(ram_en), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    dm_arbiter #(.AW(12), .FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr),
        .i_wdata(wdata), .i_code(code), .o_ack(ack2), .o_err(err2),
        .o_rdata(rdata2), .o_ram_en(ram_en2), .o_ram_we(ram_we2),
        .o_ram_addr(ram_addr2), .o_ram_wdata(ram_wdata2), .i_ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with per-byte writes and registered read (read-first)
    always @(posedge clk) begin
        if (ram_en) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int          waited;
        logic [31:0] act_rd;
        logic [31:0] act_rd2;
        req   = (v.rq == 1) ? 2'b10 : 2'b01;
        addr  = 64'h0;
        wdata = 64'h0;
        code  = 8'h00;
        if (v.rq == 1) begin
            addr[63:32] = v.addr; wdata[63:32] = v.wdata; code[7:4] = v.code;
        end else begin
            addr[31:0] = v.addr;  wdata[31:0] = v.wdata;  code[3:0] = v.code;
        end
        @(negedge clk);
        chk($sformatf("v%0d_issue_ack", idx), {30'd0, ack}, 32'd0);
        chk($sformatf("v%0d_ram_en", idx), {31'd0, ram_en}, {31'd0, v.en});
        chk($sformatf("v%0d_ram_we", idx), {28'd0, ram_we}, {28'd0, v.we});
        chk($sformatf("v%0d_fp_ram_en", idx), {31'd0, ram_en2}, {31'd0, v.en});
        chk($sformatf("v%0d_fp_ram_we", idx), {28'd0, ram_we2}, {28'd0, v.we});
        if (v.en) begin
            chk($sformatf("v%0d_ram_addr", idx), {22'd0, ram_addr}, {22'd0, v.waddr});
            chk($sformatf("v%0d_fp_ram_addr", idx), {22'd0, ram_addr2}, {22'd0, v.waddr});
        end
        if (v.we != 4'b0000) begin
            chk($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wd);
            chk($sformatf("v%0d_fp_ram_wdata", idx), ram_wdata2, v.wd);
        end
        e.ack    = (v.rq == 1) ? 2'b10 : 2'b01;
        e.err    = v.err ? e.ack : 2'b00;
        e.rdata  = v.rdata;
        e.chk_rd = v.chk_rd;
        e.rq     = v.rq;
        sbq.push_back(e);
        @(posedge clk); #1;
        @(negedge clk);
        waited = 0;
        while (ack == 2'b00 && waited < 3) begin
            @(negedge clk);
            waited++;
        end
        e = sbq.pop_front();
        if (ack == 2'b00) begin
            tests++;
            fails++;
            $display("FAIL v%0d_ack_timeout: got no ack expected %b", idx, e.ack);
        end else begin
            chk($sformatf("v%0d_ack", idx), {30'd0, ack}, {30'd0, e.ack});
            chk($sformatf("v%0d_err", idx), {30'd0, err}, {30'd0, e.err});
            chk($sformatf("v%0d_fp_ack", idx), {30'd0, ack2}, {30'd0, e.ack});
            chk($sformatf("v%0d_fp_err", idx), {30'd0, err2}, {30'd0, e.err});
            if (e.chk_rd) begin
                act_rd  = (e.rq == 1) ? rdata[63:32]  : rdata[31:0];
                act_rd2 = (e.rq == 1) ? rdata2[63:32] : rdata2[31:0];
                chk($sformatf("v%0d_rdata", idx), act_rd, e.rdata);
                chk($sformatf("v%0d_fp_rdata", idx), act_rd2, e.rdata);
            end
        end
        req = 2'b00;
        @(posedge clk); #1;
    endtask

    initial begin
        //            rq code     addr   wdata         en  we       waddr  wd            err  rdata         chk
        vecs[0]  = '{0, 4'b1000, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 10'd4,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{0, 4'b0000, 32'h10, 32'h0,        1'b1, 4'b0000, 10'd4,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        vecs[2]  = '{0, 4'b1000, 32'h30, 32'h80FF7F01, 1'b1, 4'b1111, 10'd12, 32'h80FF7F01, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{0, 4'b0011, 32'h33, 32'h0,        1'b1, 4'b0000, 10'd12, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
        vecs[4]  = '{0, 4'b0101, 32'h31, 32'h0,        1'b1, 4'b0000, 10'd12, 32'h0,        1'b0, 32'h0000007F, 1'b1};
        vecs[5]  = '{0, 4'b0010, 32'h32, 32'h0,        1'b1, 4'b0000, 10'd12, 32'h0,        1'b0, 32'hFFFF80FF, 1'b1};
        vecs[6]  = '{0, 4'b0100, 32'h30, 32'h0,        1'b1, 4'b0000, 10'd12, 32'h0,        1'b0, 32'h00007F01, 1'b1};
        vecs[7]  = '{1, 4'b0000, 32'h30, 32'h0,        1'b1, 4'b0000, 10'd12, 32'h0,        1'b0, 32'h80FF7F01, 1'b1};
        vecs[8]  = '{0, 4'b1000, 32'h20, 32'h11223344, 1'b1, 4'b1111, 10'd8,  32'h11223344, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{0, 4'b1011, 32'h22, 32'h000000AB, 1'b1, 4'b0100, 10'd8,  32'hABABABAB, 1'b0, 32'h0,        1'b0};
        vecs[10] = '{0, 4'b1010, 32'h22, 32'h00001234, 1'b1, 4'b1100, 10'd8,  32'h12341234, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{0, 4'b1010, 32'h21, 32'h0000FFFF, 1'b0, 4'b0000, 10'd8,  32'h0,        1'b1, 32'h0,        1'b1};
        vecs[12] = '{0, 4'b0000, 32'h13, 32'h0,        1'b0, 4'b0000, 10'd4,  32'h0,        1'b1, 32'h0,        1'b1};
        vecs[13] = '{0, 4'b0111, 32'h10, 32'h0,        1'b0, 4'b0000, 10'd4,  32'h0,        1'b1, 32'h0,        1'b1};
        vecs[14] = '{0, 4'b0000, 32'h20, 32'h0,        1'b1, 4'b0000, 10'd8,  32'h0,        1'b0, 32'h12343344, 1'b1};
        vecs[15] = '{1, 4'b0100, 32'h32, 32'h0,        1'b1, 4'b0000, 10'd12, 32'h0,        1'b0, 32'h000080FF, 1'b1};

        reset = 1'b0;
        req   = 2'b00;
        addr  = 64'h0;
        wdata = 64'h0;
        code  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_rdata0", rdata[31:0], 32'd0);
        chk("rst_rdata1", rdata[63:32], 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Contention: both requests held from the first cycle after reset
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 2'b11;
        addr  = {32'h30, 32'h10};
        code  = {4'b0000, 4'b0000};
        wdata = 64'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if ((c % 2) == 0) begin
                chk($sformatf("rr_c%0d_ack", c), {30'd0, ack}, 32'd0);
                chk($sformatf("rr_c%0d_ram_addr", c), {22'd0, ram_addr},
                    ((c % 4) == 0) ? 32'd4 : 32'd12);
                chk($sformatf("fp_c%0d_ram_addr", c), {22'd0, ram_addr2}, 32'd4);
            end else begin
                chk($sformatf("rr_c%0d_ack", c), {30'd0, ack},
                    ((c % 4) == 1) ? 32'd1 : 32'd2);
                chk($sformatf("fp_c%0d_ack", c), {30'd0, ack2}, 32'd1);
                if ((c % 4) == 1) begin
                    chk($sformatf("rr_c%0d_rdata0", c), rdata[31:0], 32'hDEADBEEF);
                end else begin
                    chk($sformatf("rr_c%0d_rdata1", c), rdata[63:32], 32'h80FF7F01);
                end
            end
            @(posedge clk); #1;
        end
        req = 2'b00;
        @(posedge clk); #1;

        // Reset asserted during RESP of a load aborts the ack
        req  = 2'b01;
        addr = {32'h0, 32'h10};
        code = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_ack", {30'd0, ack}, 32'd0);
        chk("rstmid_fp_ack", {30'd0, ack2}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        chk("rstpost_ack", {30'd0, ack}, 32'd0);
        chk("rstpost_err", {30'd0, err}, 32'd0);
        chk("rstpost_rdata0", rdata[31:0], 32'd0);
        chk("rstpost_rdata1", rdata[63:32], 32'd0);
        chk("rstpost_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rstpost_ram_we", {28'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        run_vec(16, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
